// File: rtl/ct_time_of_day.sv
// Time-of-day counter: prescaler -> seconds -> minutes -> hours, with day_tick at midnight.
// Optional 12-hour display with PM flag when CT_TOD_AMPM_EN is defined.
module ct_time_of_day #(
    parameter int DIV   = 1,
    parameter int DIV_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       set_mode,
    input  logic       set_min,
    input  logic       set_hr,
    output logic [5:0] secs,
    output logic [5:0] mins,
    output logic [4:0] hrs,
    output logic       sec_tick,
    output logic       day_tick,
    output logic       pm
);

    localparam logic [DIV_W-1:0] PSC_TC = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] psc_q, psc_d;
    logic [5:0]       secs_q, secs_d;
    logic [5:0]       mins_q, mins_d;
    logic [4:0]       hrs_q, hrs_d;
    logic             sec_tick_q, sec_tick_d;
    logic             day_tick_q, day_tick_d;

    always_comb begin
        psc_d      = psc_q;
        secs_d     = secs_q;
        mins_d     = mins_q;
        hrs_d      = hrs_q;
        sec_tick_d = 1'b0;
        day_tick_d = 1'b0;
        if (set_mode) begin
            // Adjustments never carry, so they can never fake a day boundary.
            psc_d  = '0;
            secs_d = '0;
            if (set_min) mins_d = (mins_q == 6'd59) ? 6'd0 : mins_q + 6'd1;
            if (set_hr)  hrs_d  = (hrs_q == 5'd23) ? 5'd0 : hrs_q + 5'd1;
        end else if (en) begin
            if (psc_q == PSC_TC) begin
                psc_d      = '0;
                sec_tick_d = 1'b1;
                if (secs_q == 6'd59) begin
                    secs_d = 6'd0;
                    if (mins_q == 6'd59) begin
                        mins_d = 6'd0;
                        if (hrs_q == 5'd23) begin
                            hrs_d      = 5'd0;
                            day_tick_d = 1'b1;
                        end else begin
                            hrs_d = hrs_q + 5'd1;
                        end
                    end else begin
                        mins_d = mins_q + 6'd1;
                    end
                end else begin
                    secs_d = secs_q + 6'd1;
                end
            end else begin
                psc_d = psc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_q      <= '0;
            secs_q     <= '0;
            mins_q     <= '0;
            hrs_q      <= '0;
            sec_tick_q <= 1'b0;
            day_tick_q <= 1'b0;
        end else begin
            psc_q      <= psc_d;
            secs_q     <= secs_d;
            mins_q     <= mins_d;
            hrs_q      <= hrs_d;
            sec_tick_q <= sec_tick_d;
            day_tick_q <= day_tick_d;
        end
    end

    assign secs     = secs_q;
    assign mins     = mins_q;
    assign sec_tick = sec_tick_q;
    assign day_tick = day_tick_q;

`ifdef CT_TOD_AMPM_EN
    // Internal register stays 0..23; only the display is folded to 1..12.
    always_comb begin
        if (hrs_q == 5'd0)      hrs = 5'd12;
        else if (hrs_q > 5'd12) hrs = hrs_q - 5'd12;
        else                    hrs = hrs_q;
    end
    assign pm = (hrs_q >= 5'd12);
`else
    assign hrs = hrs_q;
    assign pm  = 1'b0;
`endif

endmodule

// File: tb/tb_ct_time_of_day.sv
// Self-checking bench for ct_time_of_day: time model feeds a scoreboard queue of expected states.
module tb_ct_time_of_day;

    localparam int DIV   = 4;
    localparam int DIV_W = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       set_mode;
    logic       set_min;
    logic       set_hr;
    logic [5:0] secs;
    logic [5:0] mins;
    logic [4:0] hrs;
    logic       sec_tick;
    logic       day_tick;
    logic       pm;

    ct_time_of_day #(.DIV(DIV), .DIV_W(DIV_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .set_mode (set_mode),
        .set_min  (set_min),
        .set_hr   (set_hr),
        .secs     (secs),
        .mins     (mins),
        .hrs      (hrs),
        .sec_tick (sec_tick),
        .day_tick (day_tick),
        .pm       (pm)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h;
        int m;
        int s;
        int day;
    } exp_t;

    exp_t sb_q[$];
    int   tot;       // model time in seconds since midnight
    int   n_cmp = 0;
    int   n_err = 0;
    int   day_cnt = 0;

    // Downstream day-of-year counter stand-in: counts enables it would see.
    always @(negedge clk) if (day_tick) day_cnt++;

    task automatic check_val(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int disp_h(input int h);
`ifdef CT_TOD_AMPM_EN
        if (h == 0) return 12;
        if (h > 12) return h - 12;
        return h;
`else
        return h;
`endif
    endfunction

    function automatic int disp_pm(input int h);
`ifdef CT_TOD_AMPM_EN
        return (h >= 12) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int day);
        exp_t e;
        e.h   = tot / 3600;
        e.m   = (tot / 60) % 60;
        e.s   = tot % 60;
        e.day = day;
        sb_q.push_back(e);
    endtask

    task automatic compare_pop(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb_q.pop_front();
            check_val({tag, "_hrs"},  int'(hrs),      disp_h(e.h));
            check_val({tag, "_pm"},   int'(pm),       disp_pm(e.h));
            check_val({tag, "_mins"}, int'(mins),     e.m);
            check_val({tag, "_secs"}, int'(secs),     e.s);
            check_val({tag, "_day"},  int'(day_tick), e.day);
            $display("%s: %02d:%02d:%02d pm=%0d day=%0d", tag, hrs, mins, secs, pm, day_tick);
        end
    endtask

    task automatic wait_tick();
        int c = 0;
        do begin
            step();
            c++;
        end while (!sec_tick && c < 4 * DIV + 4);
        check_val("tick_lat", c, DIV);
    endtask

    task automatic run_seconds(input int n);
        for (int i = 0; i < n; i++) begin
            tot = (tot + 1) % 86400;
            push_exp((tot == 0) ? 1 : 0);
            wait_tick();
            compare_pop("sec");
        end
    endtask

    task automatic enter_set();
        set_mode = 1'b1;
        step();
        tot = tot - (tot % 60);
        push_exp(0);
        compare_pop("enter_set");
    endtask

    task automatic set_pulse(input logic mn, input logic hr);
        int h, m;
        set_min = mn;
        set_hr  = hr;
        step();
        set_min = 1'b0;
        set_hr  = 1'b0;
        h = tot / 3600;
        m = (tot / 60) % 60;
        if (mn) m = (m + 1) % 60;
        if (hr) h = (h + 1) % 24;
        tot = h * 3600 + m * 60;
        push_exp(0);
        compare_pop("set");
    endtask

    initial begin
        int seen;
        int s_hold;
        rst_n = 1'b0; en = 1'b1; set_mode = 1'b0; set_min = 1'b0; set_hr = 1'b0;
        tot = 0;
        #23;
        check_val("rst_secs", int'(secs), 0);
        check_val("rst_hrs", int'(hrs), disp_h(0));
        check_val("rst_tick", int'(sec_tick), 0);
        rst_n = 1'b1;

        // Prescaler cadence and first counts.
        run_seconds(2);

        // en low freezes everything.
        en = 1'b0; seen = 0; s_hold = int'(secs);
        repeat (10) begin
            step();
            if (sec_tick) seen++;
        end
        check_val("en_hold_ticks", seen, 0);
        check_val("en_hold_secs", int'(secs), s_hold);
        en = 1'b1;

        // set_min outside set mode is ignored.
        set_min = 1'b1; step(); set_min = 1'b0;
        push_exp(0);
        compare_pop("set_ignored");

        // Set mode: hour wrap without day_tick, minute wrap without carry, joint pulse.
        enter_set();
        repeat (25) set_pulse(1'b0, 1'b1);
        repeat (59) set_pulse(1'b1, 1'b0);
        set_pulse(1'b1, 1'b0);
        set_pulse(1'b1, 1'b1);
        check_val("set_day_cnt", day_cnt, 0);

        // Carry chain 00:59:00 -> 01:00:00.
        repeat (22) set_pulse(1'b0, 1'b1);
        repeat (58) set_pulse(1'b1, 1'b0);
        set_mode = 1'b0;
        run_seconds(60);

        // Day rollover from 23:59.
        enter_set();
        repeat (22) set_pulse(1'b0, 1'b1);
        repeat (59) set_pulse(1'b1, 1'b0);
        set_mode = 1'b0;
        run_seconds(60);
        step();
        check_val("day_one_cycle", int'(day_tick), 0);
        check_val("day_cnt", day_cnt, 1);

        // Noon and 13:00 for the display mapping.
        enter_set();
        repeat (13) set_pulse(1'b0, 1'b1);

        // Reach 10:20:30 then reset asynchronously mid-count.
        repeat (21) set_pulse(1'b0, 1'b1);
        repeat (20) set_pulse(1'b1, 1'b0);
        set_mode = 1'b0;
        run_seconds(30);
        #2 rst_n = 1'b0;
        #1;
        tot = 0;
        sb_q.delete();
        push_exp(0);
        compare_pop("async_rst");
        #1 rst_n = 1'b1;
        run_seconds(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
